param_fetch_pipe: RTL and testbench

Parametrised successor to the neuron parameter-fetch stage. For each neuron it streams `numInputs` (input, weight) pairs to the MAC stage. Each pair is fetched from three synchronous-read memories: index, input and weight. Two addressing modes: sparse (input address = indexVal + offset) and dense (input address = offset + i). Memory read latency is configurable, and an output FIFO with credit-based issue lets the downstream stall without losing reads.

---
 rtl/param_fetch_pkg.sv | 22 ++
 rtl/param_fetch_fifo.sv | 48 ++++
 rtl/param_fetch_pipe.sv | 205 ++++++++++++++++++++
 tb/tb_param_fetch_pipe.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/param_fetch_pkg.sv
// Shared types for the neuron parameter-fetch pipeline: FSM states, addressing
// modes and the output FIFO entry layout.
package param_fetch_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN
  } state_t;

  localparam logic MODE_DENSE  = 1'b0;
  localparam logic MODE_SPARSE = 1'b1;

  localparam int ENTRY_DATA_W = 16;

  typedef struct packed {
    logic                    last;
    logic [ENTRY_DATA_W-1:0] weight;
    logic [ENTRY_DATA_W-1:0] in_data;
  } fifo_entry_t;

endpackage

// File: rtl/param_fetch_fifo.sv
// Synchronous FIFO with occupancy count; a push on a full FIFO is accepted
// only when a pop happens in the same cycle.
module param_fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

endmodule

// File: rtl/param_fetch_pipe.sv
// Neuron parameter-fetch stage: issues index/input/weight reads per element,
// tracks them through the memory latency and buffers results in a credited FIFO.
module param_fetch_pipe
  import param_fetch_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 16,
  parameter int MEM_LAT    = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] numInputs,
  input  logic [ADDR_W-1:0] offset,
  input  logic [ADDR_W-1:0] weightBase,
  input  logic [ADDR_W-1:0] indexBase,
  input  logic              sparse,
  output logic [ADDR_W-1:0] indexAddr,
  output logic [ADDR_W-1:0] inputAddr,
  output logic [ADDR_W-1:0] weightAddr,
  output logic              indexRe,
  output logic              dataRe,
  input  logic [DATA_W-1:0] indexVal,
  input  logic [DATA_W-1:0] inputVal,
  input  logic [DATA_W-1:0] weightVal,
  output logic [DATA_W-1:0] neuronInput,
  output logic [DATA_W-1:0] neuronWeight,
  output logic              paramsReady,
  input  logic              readyNextParam,
  output logic              lastParam,
  output logic              busy,
  output logic              done
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  if (DATA_W != ENTRY_DATA_W) begin : g_width_check
    $error("param_fetch_pipe: DATA_W must match ENTRY_DATA_W");
  end

  state_t            state;
  logic [ADDR_W-1:0] num_q, off_q, wb_q, ib_q, cnt_q;
  logic              sparse_q;
  logic [CW-1:0]     inflight;
  logic [CW-1:0]     fifo_count;

  // Stage A (index read) tags, one slot per cycle of memory latency.
  logic              a_v    [MEM_LAT];
  logic [ADDR_W-1:0] a_i    [MEM_LAT];
  logic              a_last [MEM_LAT];

  logic              data_sparse_q;
  logic              data_last_q;
  logic [ADDR_W-1:0] in_addr_q;

  // Data read tags; slot MEM_LAT-1 lines up with returning inputVal/weightVal.
  logic              rd_v    [MEM_LAT];
  logic              rd_last [MEM_LAT];

  logic              idle_go, credit_ok, issue, issue_last;
  logic              dense_issue, sparse_issue, sel_sparse;
  logic [ADDR_W-1:0] issue_i, sel_num, sel_off, sel_wb, sel_ib;
  logic              b_go, b_last;
  logic [ADDR_W-1:0] b_i;
  logic [ADDR_W-1:0] idx_addr, in_addr_now;
  logic              push, pop, fifo_empty, fifo_full;
  fifo_entry_t       push_entry, head;

  always_comb begin
    idle_go      = (state == IDLE) && start && (numInputs != '0);
    credit_ok    = ({1'b0, inflight} + {1'b0, fifo_count}) < (CW+1)'(FIFO_DEPTH);
    issue        = idle_go || ((state == ISSUE) && credit_ok);
    issue_i      = idle_go ? '0         : cnt_q;
    sel_sparse   = idle_go ? sparse     : sparse_q;
    sel_num      = idle_go ? numInputs  : num_q;
    sel_off      = idle_go ? offset     : off_q;
    sel_wb       = idle_go ? weightBase : wb_q;
    sel_ib       = idle_go ? indexBase  : ib_q;
    issue_last   = (issue_i == (sel_num - 1'b1));
    dense_issue  = issue && (sel_sparse == MODE_DENSE);
    sparse_issue = issue && (sel_sparse == MODE_SPARSE);
  end

  assign b_go   = a_v[MEM_LAT-1];
  assign b_i    = a_i[MEM_LAT-1];
  assign b_last = a_last[MEM_LAT-1];

  // Stage B sees indexVal in the same cycle it must present the input address,
  // so the sparse address is formed combinationally and captured for holding.
  assign idx_addr    = ADDR_W'(indexVal);
  assign in_addr_now = idx_addr + off_q;
  assign inputAddr   = data_sparse_q ? in_addr_now : in_addr_q;
  assign indexRe     = a_v[0];

  assign push       = rd_v[MEM_LAT-1];
  assign pop        = !fifo_empty && readyNextParam;
  assign push_entry = '{last:    rd_last[MEM_LAT-1],
                        weight:  ENTRY_DATA_W'(weightVal),
                        in_data: ENTRY_DATA_W'(inputVal)};

  param_fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(fifo_entry_t))
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata (push_entry),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign paramsReady  = !fifo_empty;
  assign neuronInput  = fifo_empty ? '0 : DATA_W'(head.in_data);
  assign neuronWeight = fifo_empty ? '0 : DATA_W'(head.weight);
  assign lastParam    = !fifo_empty && head.last;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      num_q         <= '0;
      off_q         <= '0;
      wb_q          <= '0;
      ib_q          <= '0;
      cnt_q         <= '0;
      sparse_q      <= 1'b0;
      inflight      <= '0;
      indexAddr     <= '0;
      weightAddr    <= '0;
      in_addr_q     <= '0;
      dataRe        <= 1'b0;
      data_sparse_q <= 1'b0;
      data_last_q   <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      for (int unsigned j = 0; j < MEM_LAT; j++) begin
        a_v[j]     <= 1'b0;
        a_i[j]     <= '0;
        a_last[j]  <= 1'b0;
        rd_v[j]    <= 1'b0;
        rd_last[j] <= 1'b0;
      end
    end else begin
      done <= 1'b0;

      if (state == IDLE && start) begin
        num_q    <= numInputs;
        off_q    <= offset;
        wb_q     <= weightBase;
        ib_q     <= indexBase;
        sparse_q <= sparse;
        if (numInputs == '0) done <= 1'b1;
      end

      if (issue) begin
        cnt_q <= issue_i + 1'b1;
        busy  <= 1'b1;
        state <= issue_last ? DRAIN : ISSUE;
      end

      if (state == DRAIN && pop && head.last) begin
        state <= IDLE;
        busy  <= 1'b0;
        done  <= 1'b1;
      end

      a_v[0] <= sparse_issue;
      if (sparse_issue) begin
        indexAddr <= sel_ib + issue_i;
        a_i[0]    <= issue_i;
        a_last[0] <= issue_last;
      end
      for (int unsigned j = 1; j < MEM_LAT; j++) begin
        a_v[j]    <= a_v[j-1];
        a_i[j]    <= a_i[j-1];
        a_last[j] <= a_last[j-1];
      end

      dataRe        <= dense_issue || b_go;
      data_sparse_q <= b_go;
      data_last_q   <= dense_issue ? issue_last : b_last;
      if (data_sparse_q) in_addr_q <= in_addr_now;
      if (dense_issue) begin
        weightAddr <= sel_wb + issue_i;
        in_addr_q  <= sel_off + issue_i;
      end else if (b_go) begin
        weightAddr <= wb_q + b_i;
      end

      rd_v[0]    <= dataRe;
      rd_last[0] <= data_last_q;
      for (int unsigned j = 1; j < MEM_LAT; j++) begin
        rd_v[j]    <= rd_v[j-1];
        rd_last[j] <= rd_last[j-1];
      end

      inflight <= inflight + CW'(issue) - CW'(push);
    end
  end

endmodule

// File: tb/tb_param_fetch_pipe.sv
// Bench for param_fetch_pipe: two instances (MEM_LAT 1 and 3) with memory
// models, an address/data scoreboard, a vector table and hand-written corner cases.
module tb_param_fetch_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_s [2];
  logic [15:0] numInputs, offset, weightBase, indexBase;
  logic        sparse;
  logic        readyNextParam;

  logic [15:0] indexAddr_s [2], inputAddr_s [2], weightAddr_s [2];
  logic        indexRe_s [2], dataRe_s [2];
  logic [15:0] indexVal_s [2], inputVal_s [2], weightVal_s [2];
  logic [15:0] neuronInput_s [2], neuronWeight_s [2];
  logic        paramsReady_s [2], lastParam_s [2], busy_s [2], done_s [2];

  always #5 clk = ~clk;

  param_fetch_pipe #(.DATA_W(16), .ADDR_W(16), .MEM_LAT(1), .FIFO_DEPTH(4)) dut0 (
    .clk(clk), .rst(rst), .start(start_s[0]), .numInputs(numInputs), .offset(offset),
    .weightBase(weightBase), .indexBase(indexBase), .sparse(sparse),
    .indexAddr(indexAddr_s[0]), .inputAddr(inputAddr_s[0]), .weightAddr(weightAddr_s[0]),
    .indexRe(indexRe_s[0]), .dataRe(dataRe_s[0]), .indexVal(indexVal_s[0]),
    .inputVal(inputVal_s[0]), .weightVal(weightVal_s[0]), .neuronInput(neuronInput_s[0]),
    .neuronWeight(neuronWeight_s[0]), .paramsReady(paramsReady_s[0]),
    .readyNextParam(readyNextParam), .lastParam(lastParam_s[0]), .busy(busy_s[0]),
    .done(done_s[0]));

  param_fetch_pipe #(.DATA_W(16), .ADDR_W(16), .MEM_LAT(3), .FIFO_DEPTH(8)) dut1 (
    .clk(clk), .rst(rst), .start(start_s[1]), .numInputs(numInputs), .offset(offset),
    .weightBase(weightBase), .indexBase(indexBase), .sparse(sparse),
    .indexAddr(indexAddr_s[1]), .inputAddr(inputAddr_s[1]), .weightAddr(weightAddr_s[1]),
    .indexRe(indexRe_s[1]), .dataRe(dataRe_s[1]), .indexVal(indexVal_s[1]),
    .inputVal(inputVal_s[1]), .weightVal(weightVal_s[1]), .neuronInput(neuronInput_s[1]),
    .neuronWeight(neuronWeight_s[1]), .paramsReady(paramsReady_s[1]),
    .readyNextParam(readyNextParam), .lastParam(lastParam_s[1]), .busy(busy_s[1]),
    .done(done_s[1]));

  // Memories: synchronous read, data visible MEM_LAT cycles after the strobe.
  logic [15:0] idx_mem [65536];
  logic [15:0] in_mem  [65536];
  logic [15:0] w_mem   [65536];
  logic [15:0] ixp [2][3], inp [2][3], wtp [2][3];

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      ixp[d][0] <= indexRe_s[d] ? idx_mem[indexAddr_s[d]] : 16'hDEAD;
      inp[d][0] <= dataRe_s[d]  ? in_mem[inputAddr_s[d]]  : 16'hDEAD;
      wtp[d][0] <= dataRe_s[d]  ? w_mem[weightAddr_s[d]]  : 16'hDEAD;
      for (int k = 1; k < 3; k++) begin
        ixp[d][k] <= ixp[d][k-1];
        inp[d][k] <= inp[d][k-1];
        wtp[d][k] <= wtp[d][k-1];
      end
    end
  end

  assign indexVal_s[0]  = ixp[0][0];
  assign inputVal_s[0]  = inp[0][0];
  assign weightVal_s[0] = wtp[0][0];
  assign indexVal_s[1]  = ixp[1][2];
  assign inputVal_s[1]  = inp[1][2];
  assign weightVal_s[1] = wtp[1][2];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int s0 = 0;
  int cur = 0;
  int first_rdy, done_cnt, done_cyc, dre_cnt;
  logic busy1;
  bit rnd_ready = 1'b0;
  bit ready_hold = 1'b1;

  logic [32:0] qd [$];
  logic [31:0] qa [$];
  logic [15:0] qi [$];

  typedef struct {
    int d; bit sp; int n;
    logic [15:0] off, wb, ib;
    int rdy; bit rnd;
  } vec_t;
  vec_t tbl [6];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic [127:0] outs(input int d);
    return {42'b0, indexAddr_s[d], inputAddr_s[d], weightAddr_s[d], neuronInput_s[d],
            neuronWeight_s[d], indexRe_s[d], dataRe_s[d], paramsReady_s[d],
            lastParam_s[d], busy_s[d], done_s[d]};
  endfunction

  task automatic monitor();
    int rel;
    rel = cyc - s0;
    if (rel == 1) busy1 = busy_s[cur];
    if (paramsReady_s[cur] === 1'b1 && first_rdy < 0) first_rdy = rel;
    if (indexRe_s[cur] === 1'b1) begin
      if (qi.size() == 0) chk("unexpected_indexRe", 1, 0);
      else chk("indexAddr", indexAddr_s[cur], qi.pop_front());
    end
    if (dataRe_s[cur] === 1'b1) begin
      dre_cnt++;
      if (qa.size() == 0) chk("unexpected_dataRe", 1, 0);
      else chk("input_weight_addr", {inputAddr_s[cur], weightAddr_s[cur]}, qa.pop_front());
    end
    if (paramsReady_s[cur] === 1'b1 && readyNextParam) begin
      if (qd.size() == 0) chk("unexpected_pop", 1, 0);
      else chk("pop_data", {lastParam_s[cur], neuronWeight_s[cur], neuronInput_s[cur]},
               qd.pop_front());
    end
    if (done_s[cur] === 1'b1) begin
      done_cnt++;
      done_cyc = rel;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
    readyNextParam = rnd_ready ? ($urandom_range(0, 3) != 0) : ready_hold;
    monitor();
  endtask

  task automatic load_exp(input bit sp, input int n, input logic [15:0] off, wb, ib);
    logic [15:0] a, wa, ia;
    qd.delete(); qa.delete(); qi.delete();
    for (int i = 0; i < n; i++) begin
      ia = ib + 16'(i);
      wa = wb + 16'(i);
      a  = sp ? (idx_mem[ia] + off) : (off + 16'(i));
      if (sp) qi.push_back(ia);
      qa.push_back({a, wa});
      qd.push_back({(i == n - 1), w_mem[wa], in_mem[a]});
    end
  endtask

  task automatic launch(input int d, input bit sp, input int n, input logic [15:0] off, wb, ib);
    cur = d;
    load_exp(sp, n, off, wb, ib);
    first_rdy = -1; done_cnt = 0; done_cyc = -1; dre_cnt = 0; busy1 = 1'b0;
    sparse = sp; numInputs = 16'(n); offset = off; weightBase = wb; indexBase = ib;
    start_s[d] = 1'b1;
    s0 = cyc;
    tick();
    start_s[d] = 1'b0;
  endtask

  task automatic finish_run(input int d, input int n);
    for (int k = 0; k < 400 && done_cnt == 0; k++) tick();
    rnd_ready = 1'b0;
    tick();
    tick();
    chk("done_once", done_cnt, 1);
    chk("scoreboard_empty", qd.size() + qa.size() + qi.size(), 0);
    chk("busy_after", busy_s[d], 0);
    if (n == 0) chk("zero_done_cycle", done_cyc, 1);
  endtask

  task automatic run(input vec_t v);
    launch(v.d, v.sp, v.n, v.off, v.wb, v.ib);
    rnd_ready = v.rnd;
    finish_run(v.d, v.n);
    chk("first_ready_cycle", first_rdy, v.rdy);
    chk("busy_cycle1", busy1, (v.n > 0));
  endtask

  initial begin
    tbl[0] = '{0, 1'b1, 3, 16'hFFF0, 16'h0200, 16'h0000, 4, 1'b0};
    tbl[1] = '{0, 1'b0, 5, 16'h0100, 16'h0040, 16'h0000, 3, 1'b0};
    tbl[2] = '{0, 1'b1, 1, 16'h0010, 16'h0300, 16'h0005, 4, 1'b0};
    tbl[3] = '{0, 1'b0, 8, 16'hFFFC, 16'hFFFE, 16'h0000, 3, 1'b0};
    tbl[4] = '{0, 1'b0, 0, 16'h0000, 16'h0000, 16'h0000, -1, 1'b0};
    tbl[5] = '{1, 1'b0, 6, 16'h0010, 16'h0080, 16'h0000, 5, 1'b1};

    for (int a = 0; a < 65536; a++) begin
      in_mem[a]  = 16'(a);
      w_mem[a]   = 16'(a) ^ 16'hA5A5;
      idx_mem[a] = 16'(a) + 16'h0020;
    end

    start_s[0] = 1'b0; start_s[1] = 1'b0;
    sparse = 1'b0; numInputs = '0; offset = '0; weightBase = '0; indexBase = '0;
    readyNextParam = 1'b1;
    rst = 1'b1;
    repeat (3) tick();
    chk("reset_outputs_lat1", outs(0), 0);
    chk("reset_outputs_lat3", outs(1), 0);
    rst = 1'b0;
    tick();

    foreach (tbl[t]) run(tbl[t]);

    // Backpressure with a start pulse and new parameters mid-neuron.
    ready_hold = 1'b0;
    launch(0, 1'b0, 10, 16'h0000, 16'h0300, 16'h0000);
    repeat (9) tick();
    sparse = 1'b1; numInputs = 16'd2; offset = 16'h0777; weightBase = 16'h0999;
    start_s[0] = 1'b1;
    tick();
    start_s[0] = 1'b0;
    repeat (9) tick();
    chk("bp_strobes", dre_cnt, 4);
    chk("bp_ready_no_strobe", {paramsReady_s[0], dataRe_s[0]}, 2'b10);
    chk("bp_no_pop", qd.size(), 10);
    ready_hold = 1'b1;
    finish_run(0, 10);
    chk("bp_total_strobes", dre_cnt, 10);

    // Reset during DRAIN with two entries buffered.
    ready_hold = 1'b0;
    launch(0, 1'b0, 2, 16'h0050, 16'h0060, 16'h0000);
    repeat (5) tick();
    chk("pre_reset_state", {busy_s[0], paramsReady_s[0], dataRe_s[0]}, 3'b110);
    qd.delete(); qa.delete(); qi.delete();
    rst = 1'b1;
    tick();
    chk("mid_reset_outputs", outs(0), 0);
    rst = 1'b0;
    ready_hold = 1'b1;
    tick();
    run(tbl[0]);

    // Latency-3 sparse sweep over random memories.
    for (int a = 0; a < 65536; a++) begin
      in_mem[a]  = 16'($urandom);
      w_mem[a]   = 16'($urandom);
      idx_mem[a] = 16'($urandom);
    end
    run('{1, 1'b1, 12, 16'($urandom), 16'h2000, 16'h1000, 8, 1'b1});
    run('{1, 1'b1, 5, 16'hFFF0, 16'hFFFE, 16'hFFFD, 8, 1'b0});
    run('{0, 1'b1, 9, 16'($urandom), 16'h0400, 16'h0800, 4, 1'b1});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
